// File: rtl/score_link_pkg.sv
// Score link frame layout shared by the UART transmit packer and receive unpacker.
// Frame is {board_ID[7:0], points[23:0]}, sent MSB byte first.
package score_link_pkg;

  localparam int FRAME_BYTES = 4;
  localparam int ID_W        = 8;
  localparam int POINTS_W    = 24;
  localparam int FRAME_W     = ID_W + POINTS_W;

  // Bit positions of the fields inside the 32-bit frame word
  localparam int ID_MSB  = FRAME_W - 1;
  localparam int ID_LSB  = POINTS_W;
  localparam int PTS_MSB = POINTS_W - 1;
  localparam int PTS_LSB = 0;

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic [POINTS_W-1:0] points;
  } score_frame_t;

  // Position of a byte inside the frame, in wire order
  typedef enum logic [1:0] {
    BYTE_ID    = 2'd0,
    BYTE_P_HI  = 2'd1,
    BYTE_P_MID = 2'd2,
    BYTE_P_LO  = 2'd3
  } byte_idx_e;

  // Board ID 0 marks an empty frame that carries no score
  function automatic logic frame_is_empty(input score_frame_t f);
    return (f.id == '0);
  endfunction

endpackage

// File: rtl/data_from_transfer.sv
// Reassembles 4-byte score frames popped from a UART RX FIFO (FWFT).
// Ports: clk, rst (async, active-low), rx_empty/rx_data from FIFO, rd_uart pop,
// rx_board_ID/rx_points frame outputs, frame_valid/frame_drop/sync_err pulses.
module data_from_transfer
  import score_link_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 200000,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_empty,
  input  logic [7:0]          rx_data,
  output logic                rd_uart,
  output logic [ID_W-1:0]     rx_board_ID,
  output logic [POINTS_W-1:0] rx_points,
  output logic                frame_valid,
  output logic                frame_drop,
  output logic                sync_err
);

  // Expiry fires on the edge where the counter would reach TIMEOUT_CYCLES-1
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  byte_idx_e           byte_cnt_q;
  logic [POINTS_W-1:0] shift_q;
  logic [CNT_W-1:0]    tmo_q;

  logic                capture;
  logic                last_byte;
  logic                tmo_hit;
  score_frame_t        word;

  // FIFO flag is stale during the pop cycle, so no capture then
  assign capture   = !rx_empty && !rd_uart;
  assign last_byte = (byte_cnt_q == BYTE_P_LO);
  assign tmo_hit   = (tmo_q == TMO_LAST);
  assign word      = {shift_q, rx_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q  <= BYTE_ID;
      shift_q     <= '0;
      tmo_q       <= '0;
      rd_uart     <= 1'b0;
      rx_board_ID <= '0;
      rx_points   <= '0;
      frame_valid <= 1'b0;
      frame_drop  <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      rd_uart     <= 1'b0;
      frame_valid <= 1'b0;
      frame_drop  <= 1'b0;
      sync_err    <= 1'b0;
      if (capture) begin
        // A capture always beats a coincident expiry
        rd_uart <= 1'b1;
        tmo_q   <= '0;
        if (last_byte) begin
          byte_cnt_q <= BYTE_ID;
          shift_q    <= '0;
          if (frame_is_empty(word)) begin
            frame_drop <= 1'b1;
          end else begin
            rx_board_ID <= word.id;
            rx_points   <= word.points;
            frame_valid <= 1'b1;
          end
        end else begin
          shift_q    <= {shift_q[POINTS_W-9:0], rx_data};
          byte_cnt_q <= byte_idx_e'(byte_cnt_q + 2'd1);
        end
      end else if (byte_cnt_q != BYTE_ID) begin
        if (tmo_hit) begin
          byte_cnt_q <= BYTE_ID;
          shift_q    <= '0;
          tmo_q      <= '0;
          sync_err   <= 1'b1;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_from_transfer.sv
// Randomized and directed bench for data_from_transfer with a FIFO model
// and an expected-event queue derived from the frames sent.
module tb_data_from_transfer;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_empty = 1'b1;
  logic [7:0]  rx_data  = 8'h00;
  logic        rd_uart;
  logic [7:0]  rx_board_ID;
  logic [23:0] rx_points;
  logic        frame_valid;
  logic        frame_drop;
  logic        sync_err;

  always #5 clk = ~clk;

  data_from_transfer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .rd_uart     (rd_uart),
    .rx_board_ID (rx_board_ID),
    .rx_points   (rx_points),
    .frame_valid (frame_valid),
    .frame_drop  (frame_drop),
    .sync_err    (sync_err)
  );

  // kind: 0 = valid frame, 1 = dropped frame, 2 = sync error
  typedef struct {
    int          kind;
    logic [7:0]  id;
    logic [23:0] pts;
  } ev_t;

  logic [7:0]  fq[$];
  ev_t         eq[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          pops   = 0;
  int          n_sync = 0;
  logic        prev_rd = 1'b0;
  logic [7:0]  m_id  = 8'h00;
  logic [23:0] m_pts = 24'h0;
  ev_t         me;
  int          mk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // FIFO model and event monitor, away from the active edge
  always @(negedge clk) begin
    if (rd_uart) begin
      chk("pop_nonempty", 32'(fq.size() != 0), 1);
      chk("rd_one_cycle", 32'(prev_rd), 0);
      if (fq.size() != 0) void'(fq.pop_front());
      pops++;
    end
    prev_rd = rd_uart;
    if (sync_err) n_sync++;
    if (frame_valid || frame_drop || sync_err) begin
      chk("excl", 32'(frame_valid) + 32'(frame_drop) + 32'(sync_err), 1);
      chk("ev_expected", 32'(eq.size() != 0), 1);
      if (eq.size() != 0) begin
        me = eq.pop_front();
        mk = frame_valid ? 0 : (frame_drop ? 1 : 2);
        chk("ev_kind", 32'(mk), 32'(me.kind));
        if (frame_valid) begin
          chk("ev_id", 32'(rx_board_ID), 32'(me.id));
          chk("ev_pts", 32'(rx_points), 32'(me.pts));
        end
      end
    end
    rx_empty = (fq.size() == 0);
    rx_data  = (fq.size() != 0) ? fq[0] : 8'hEE;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_frame(input logic [7:0] id, input logic [23:0] pts);
    ev_t e;
    e.id  = id;
    e.pts = pts;
    if (id != 8'h00) begin
      e.kind = 0;
      m_id   = id;
      m_pts  = pts;
    end else begin
      e.kind = 1;
    end
    eq.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [23:0] pts,
                            input int gap_max);
    expect_frame(id, pts);
    fq.push_back(id);
    cyc($urandom_range(0, gap_max));
    fq.push_back(pts[23:16]);
    cyc($urandom_range(0, gap_max));
    fq.push_back(pts[15:8]);
    cyc($urandom_range(0, gap_max));
    fq.push_back(pts[7:0]);
  endtask

  task automatic expect_sync();
    ev_t e;
    e.kind = 2;
    e.id   = 8'h00;
    e.pts  = 24'h0;
    eq.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((fq.size() != 0 || eq.size() != 0 || rd_uart) && t < 400) begin
      cyc(1);
      t++;
    end
    chk("drain", 32'(t < 400), 1);
    eq.delete();
    cyc(3);
  endtask

  task automatic wait_pops(input int n);
    int c;
    int t;
    c = 0;
    t = 0;
    while (c < n && t < 100) begin
      cyc(1);
      t++;
      if (rd_uart) c++;
    end
    chk("wait_pops", 32'(c), 32'(n));
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_id"}, 32'(rx_board_ID), 32'(m_id));
    chk({tag, "_pts"}, 32'(rx_points), 32'(m_pts));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd"}, 32'(rd_uart), 0);
    chk({tag, "_id"}, 32'(rx_board_ID), 0);
    chk({tag, "_pts"}, 32'(rx_points), 0);
    chk({tag, "_fv"}, 32'(frame_valid), 0);
    chk({tag, "_fd"}, 32'(frame_drop), 0);
    chk({tag, "_se"}, 32'(sync_err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int s0;
    int cnt;
    int k;
    int r;
    int nb;
    logic [7:0]  id;
    logic [23:0] pts;

    rst = 1'b0;
    cyc(2);
    chk_zero("reset");
    rst = 1'b1;
    cyc(2);

    // basic frame: 4 pops on alternating cycles
    p0 = pops;
    expect_frame(8'h02, 24'h00012C);
    fq.push_back(8'h02); fq.push_back(8'h00);
    fq.push_back(8'h01); fq.push_back(8'h2C);
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (rd_uart) cnt++;
    end
    chk("basic_window_pops", 32'(cnt), 4);
    drain();
    chk("basic_pops", 32'(pops - p0), 4);
    chk_hold("basic");

    // zero-ID frame is dropped, outputs hold
    p0 = pops;
    send_frame(8'h00, 24'h123456, 0);
    drain();
    chk("zero_pops", 32'(pops - p0), 4);
    chk_hold("zero");

    // timeout: sync_err 15 cycles after the second capture
    expect_sync();
    fq.push_back(8'h05); fq.push_back(8'h00);
    wait_pops(2);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      cyc(1);
      if (sync_err) k = i;
    end
    chk("sync_delay", 32'(k), 15);
    drain();
    send_frame(8'h03, 24'h00000A, 2);
    drain();
    chk_hold("resync");

    // byte lands on the expiry edge: capture wins
    s0 = n_sync;
    expect_frame(8'h05, 24'h000102);
    fq.push_back(8'h05);
    wait_pops(1);
    cyc(14);
    fq.push_back(8'h00); fq.push_back(8'h01); fq.push_back(8'h02);
    drain();
    chk("no_sync_on_capture", 32'(n_sync - s0), 0);
    chk_hold("expiry");

    // back-to-back: 8 pops in 16 cycles
    expect_frame(8'h01, 24'hAABBCC);
    expect_frame(8'h04, 24'h000001);
    fq.push_back(8'h01); fq.push_back(8'hAA);
    fq.push_back(8'hBB); fq.push_back(8'hCC);
    fq.push_back(8'h04); fq.push_back(8'h00);
    fq.push_back(8'h00); fq.push_back(8'h01);
    cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      if (rd_uart) cnt++;
    end
    chk("b2b_window_pops", 32'(cnt), 8);
    drain();
    chk_hold("b2b");

    // reset mid-frame
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    wait_pops(2);
    cyc(1);
    rst = 1'b0;
    #1;
    chk_zero("midreset");
    m_id  = 8'h00;
    m_pts = 24'h0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    send_frame(8'h07, 24'h000063, 1);
    drain();
    chk_hold("postreset");

    // randomized frames, drops and partial frames
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 7);
      if (r == 0) begin
        nb = $urandom_range(1, 3);
        expect_sync();
        for (int b = 0; b < nb; b++) begin
          fq.push_back(8'($urandom_range(0, 255)));
          cyc($urandom_range(0, 3));
        end
        drain();
      end else begin
        id  = (r == 1) ? 8'h00 : 8'($urandom_range(0, 255));
        pts = 24'($urandom_range(0, 32'hFFFFFF));
        send_frame(id, pts, 4);
      end
      if (it % 10 == 9) begin
        drain();
        chk_hold("rand");
      end
    end
    drain();
    chk_hold("final");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_from_transfer.md
Name: data_from_transfer

Overview:
- Receive-side counterpart of the 32-bit score frame {board_ID[7:0], points[23:0]} sent between boards over UART.
- Pops bytes from the UART RX FIFO, reassembles 4-byte frames and presents the opponent's board ID and points as registered outputs with a one-cycle valid pulse.
- Sits between the UART RX FIFO and the game/score display logic.
- Discards empty (ID 0) frames and resynchronises after an inter-byte timeout.

Parameters:
- TIMEOUT_CYCLES, 200000: idle clocks allowed between bytes of one frame before the partial frame is discarded.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the timeout counter (derived; not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- rx_empty  in  1  UART RX FIFO empty flag
- rx_data  in  8  UART RX FIFO head byte (first-word-fall-through)
- rd_uart  out  1  FIFO pop, one-cycle registered pulse
- rx_board_ID  out  8  board ID of last accepted frame
- rx_points  out  24  points of last accepted frame
- frame_valid  out  1  one-cycle pulse: rx_board_ID/rx_points just updated
- frame_drop  out  1  one-cycle pulse: complete frame with ID 0 discarded
- sync_err  out  1  one-cycle pulse: partial frame discarded on timeout

Behaviour:
- Reset: clk and rst is one clock; reset is asynchronous and active-low. Any state returns to the reset state immediately, including mid-frame. In reset:
  - all outputs are 0;
  - byte_cnt = 0, shift register = 0, timeout counter = 0.
- Capture condition: rx_empty==0 && rd_uart==0.
- On every capture edge:
  - rx_data is taken;
  - rd_uart <= 1 for exactly one cycle;
  - the timeout counter is cleared.
- While rd_uart is high, no capture is made. The flag settles after the pop, so at most one byte is taken every 2 cycles.
- Byte order is MSB first: byte0 = board_ID, byte1 = points[23:16], byte2 = points[15:8], byte3 = points[7:0].
- byte_cnt (0..3) counts bytes. Bytes 0-2 shift into a 24-bit register, and byte_cnt is incremented.
- On capturing byte 3 (same edge), with word = {shift[23:0], rx_data}:
  - if word[31:24] != 0: rx_board_ID <= word[31:24], rx_points <= word[23:0], frame_valid <= 1;
  - otherwise frame_drop <= 1, and rx_board_ID/rx_points hold their previous values;
  - byte_cnt <= 0.
- Latency: frame outputs change on the same edge that raises the final rd_uart.
- Timeout: while byte_cnt != 0 and no capture, the counter increments each cycle. When it reaches TIMEOUT_CYCLES-1:
  - byte_cnt <= 0, counter <= 0;
  - sync_err <= 1 for one cycle.
- While byte_cnt == 0, the counter is held at 0.
- Simultaneous capture and timeout expiry: the capture wins, the counter clears and there is no sync_err.
- frame_valid, frame_drop and sync_err are mutually exclusive and default to 0 every cycle.
- FIFO underflow is impossible: rd_uart is only raised after a cycle in which rx_empty was 0.

Decomposition:
- Shared package (score_link_pkg):
  - FRAME_BYTES = 4, ID_W = 8, POINTS_W = 24;
  - frame layout constants, shared with the transmit-side packer.
- No sub-module: FSM, counter and shift register fit in one module of roughly 150 lines.

Test Plan:
- Basic frame: FIFO holds 0x02,0x00,0x01,0x2C with rx_empty low → exactly 4 rd_uart pulses on alternating cycles; one frame_valid; rx_board_ID=0x02, rx_points=0x00012C.
- Zero-ID frame: after the basic frame, send 0x00,0x12,0x34,0x56 → frame_drop for one cycle, no frame_valid; outputs stay 0x02/0x00012C.
- Timeout resync (TIMEOUT_CYCLES=16): send 0x05,0x00, then hold rx_empty=1 → sync_err exactly 15 cycles after the second capture. Then send 0x03,0x00,0x00,0x0A → rx_board_ID=0x03, rx_points=0x00000A.
- Capture vs expiry: a byte arrives on the exact expiry cycle → no sync_err; byte_cnt advances.
- Back-to-back: 8 bytes queued (0x01,0xAA,0xBB,0xCC,0x04,0x00,0x00,0x01) → exactly 8 pops over 16 cycles; two frame_valid pulses with values 0x01/0xAABBCC, then 0x04/0x000001.
- Reset mid-frame: assert rst low after 2 bytes → outputs 0 asynchronously. After release, a full frame 0x07,0x00,0x00,0x63 → rx_board_ID=0x07, rx_points=99; no stale bytes merged.
